eth_udp_rx_buffer: RTL
======================

ETH_UDP_RX_BUFFER -- requirements
Module: eth_udp_rx_buffer

Interface
REQ-001 SHALL have parameters: MAX_LEN, 512, largest accepted payload in bytes; ADDR_W, 9, buffer address width (2^ADDR_W >= MAX_LEN).
REQ-002 SHALL have ports:
- rgmii_clk  in  1  sole clock.
- rstn  in  1  reset, asynchronous, active-low.
- udp_rec_data_valid  in  1  UDP payload byte strobe from the UDP/IP/MAC stack; high contiguously for one packet.
- udp_rec_rdata  in  8  payload byte.
- udp_rec_data_length  in  16  payload byte count of the current packet; stable while valid is high.
- rd_start  in  1  one-cycle pulse requesting readout of the held frame.
- out_ready  in  1  downstream can accept a byte.
- frame_ready  out  1  complete frame held, awaiting rd_start.
- frame_len  out  16  byte count of the held frame.
- out_valid  out  1  out_data is valid.
- out_data  out  8  frame byte.
- out_last  out  1  high with the final byte of the frame.
- drop_cnt  out  16  packets discarded (busy or bad length).
- err_cnt  out  16  packets whose byte count did not match length.

Function
REQ-003 SHALL detect packet start as udp_rec_data_valid high while it was low the previous cycle, and packet end as valid low while it was high the previous cycle.
REQ-004 SHALL implement FSM states IDLE, RECV, DROP, READY, READ.
REQ-005 IDLE: on packet start, SHALL sample L = udp_rec_data_length; if L==0 or L>MAX_LEN, go DROP and increment drop_cnt; else write the byte at address 0, set byte count to 1, go RECV.
REQ-006 IDLE SHALL ignore valid bytes not accompanied by packet start (stream already in progress after reset or readout).
REQ-007 RECV: each valid byte SHALL be written at address = byte count, then the count increments; bytes with count >= L SHALL NOT be written but SHALL be counted.
REQ-008 RECV on packet end: if count == L, go READY with frame_len = L; otherwise increment err_cnt and go IDLE.
REQ-009 DROP SHALL discard bytes and return to IDLE on packet end.
REQ-010 READY SHALL assert frame_ready; on rd_start, go READ and deassert frame_ready the next cycle.
REQ-011 In READY and READ, each packet start SHALL increment drop_cnt; its bytes SHALL NOT touch the buffer.
REQ-012 READ SHALL present bytes 0..frame_len-1 in order on out_data with out_valid; a byte transfers when out_valid and out_ready are both high; out_data/out_valid SHALL hold while out_ready is low.
REQ-013 First out_valid SHALL assert no later than 2 cycles after rd_start; with out_ready held high, one byte SHALL transfer per cycle (no bubbles).
REQ-014 out_last SHALL be high only with byte frame_len-1; after its transfer the FSM SHALL return to IDLE with out_valid low the next cycle.
REQ-015 rd_start outside READY SHALL be ignored.
REQ-016 drop_cnt and err_cnt SHALL saturate at 16'hFFFF.
REQ-017 frame_len SHALL hold its value until the next frame reaches READY.

Reset
REQ-018 On rstn low, SHALL asynchronously set state IDLE and frame_ready, out_valid, out_last to 0; out_data, frame_len, drop_cnt, err_cnt to 0.
REQ-019 Reset mid-RECV or mid-READ SHALL abandon the frame; buffer contents are don't-care.
REQ-020 After rstn release, a packet already in progress SHALL be ignored until its packet end (per REQ-006).

Verification
REQ-021 Packet L=512, bytes 0x00..0xFF twice, rd_start, out_ready=1 -> frame_ready=1, frame_len=512; 512 consecutive out_valid beats matching the input; out_last on beat 512; return to IDLE.
REQ-022 Packet L=600 -> drop_cnt=1, frame_ready stays 0; L=0 -> drop_cnt=2.
REQ-023 Packet L=20 with only 18 bytes -> err_cnt=1, IDLE; packet L=4 with 6 bytes -> err_cnt=2.
REQ-024 Frame held in READY, second packet L=8 arrives -> drop_cnt+1, readout still returns the first frame unchanged.
REQ-025 Readout L=4 with out_ready toggled 1,0,0,1,1,0,1 -> bytes delivered once each, in order, out_data stable during stalls.
REQ-026 rstn pulsed low mid-READ -> outputs zero immediately; next packet L=2 received and read correctly.

Source files
------------

// File: rtl/eth_udp_rx_buffer_if.sv
// eth_udp_rx_buffer_if: UDP payload ingress and frame readout signals of the receive buffer
interface eth_udp_rx_buffer_if;
  logic        udp_rec_data_valid;
  logic [7:0]  udp_rec_rdata;
  logic [15:0] udp_rec_data_length;
  logic        rd_start;
  logic        out_ready;
  logic        frame_ready;
  logic [15:0] frame_len;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;
  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, rd_start, out_ready,
    input  frame_ready, frame_len, out_valid, out_data, out_last, drop_cnt, err_cnt
  );
  modport slave (
    input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, rd_start, out_ready,
    output frame_ready, frame_len, out_valid, out_data, out_last, drop_cnt, err_cnt
  );
endinterface

// File: rtl/eth_udp_rx_buffer.sv
// eth_udp_rx_buffer: captures one UDP payload into a frame buffer and streams it out on request
module eth_udp_rx_buffer #(
  parameter int MAX_LEN = 512,
  parameter int ADDR_W  = 9
) (
  input logic rgmii_clk,
  input logic rstn,
  eth_udp_rx_buffer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RECV, DROP, READY, READ} state_t;
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  state_t state_q, state_d;
  logic vld_q;
  logic [15:0] len_q, len_d, cnt_q, cnt_d, flen_q, flen_d, drop_q, drop_d, err_q, err_d, ridx_q, ridx_d;
  logic ov_q, ov_d, ol_q, ol_d;
  logic [7:0] od_q, od_d;
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0] mem [2**ADDR_W];
  logic start, pend;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
  assign start = bus.udp_rec_data_valid & ~vld_q;
  assign pend  = ~bus.udp_rec_data_valid & vld_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    flen_d  = flen_q;
    drop_d  = drop_q;
    err_d   = err_q;
    ridx_d  = ridx_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    od_d    = od_q;
    we      = 1'b0;
    waddr   = cnt_q[ADDR_W-1:0];
    case (state_q)
      IDLE: if (start) begin
        len_d = bus.udp_rec_data_length;
        if (bus.udp_rec_data_length == 16'd0 || bus.udp_rec_data_length > MAX_L) begin
          state_d = DROP;
          drop_d  = sat_inc(drop_q);
        end else begin
          we      = 1'b1;
          waddr   = '0;
          cnt_d   = 16'd1;
          state_d = RECV;
        end
      end
      RECV: if (pend) begin
        state_d = (cnt_q == len_q) ? READY : IDLE;
        flen_d  = (cnt_q == len_q) ? len_q : flen_q;
        err_d   = (cnt_q == len_q) ? err_q : sat_inc(err_q);
      end else if (bus.udp_rec_data_valid) begin
        we    = cnt_q < len_q;
        cnt_d = sat_inc(cnt_q);
      end
      DROP: state_d = pend ? IDLE : DROP;
      READY: begin
        drop_d = start ? sat_inc(drop_q) : drop_q;
        if (bus.rd_start) begin
          state_d = READ;
          ov_d    = 1'b1;
          od_d    = mem[0];
          ol_d    = flen_q == 16'd1;
          ridx_d  = 16'd1;
        end
      end
      READ: begin
        drop_d = start ? sat_inc(drop_q) : drop_q;
        // Next byte is fetched on each accepted beat so a held-high ready never sees a gap
        if (ov_q && bus.out_ready) begin
          if (ol_q) begin
            state_d = IDLE;
            ov_d    = 1'b0;
            ol_d    = 1'b0;
          end else begin
            od_d   = mem[ridx_q[ADDR_W-1:0]];
            ol_d   = ridx_q == flen_q - 16'd1;
            ridx_d = ridx_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Valid history resets high so a packet already streaming at release is not seen as a start
  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      vld_q   <= 1'b1;
      len_q   <= '0;
      cnt_q   <= '0;
      flen_q  <= '0;
      drop_q  <= '0;
      err_q   <= '0;
      ridx_q  <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= bus.udp_rec_data_valid;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      flen_q  <= flen_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      ridx_q  <= ridx_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      od_q    <= od_d;
    end
  end
  always_ff @(posedge rgmii_clk) begin
    if (we) mem[waddr] <= bus.udp_rec_rdata;
  end
  assign bus.frame_ready = state_q == READY;
  assign bus.frame_len   = flen_q;
  assign bus.out_valid   = ov_q;
  assign bus.out_data    = od_q;
  assign bus.out_last    = ol_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.err_cnt     = err_q;
endmodule
